// File: rtl/i2c_arbiter.sv
// Two-requester round-robin arbiter in front of a single I2C master.
// Define I2C_ARBITER_TIMEOUT_EN to compile in the WAIT timeout counter and abort pulse.
module i2c_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,

    input  logic       req0,
    input  logic [6:0] addr0,
    input  logic       rw0,
    input  logic [7:0] wdata0,
    output logic       done0,
    output logic [7:0] rdata0,
    output logic       err0,

    input  logic       req1,
    input  logic [6:0] addr1,
    input  logic       rw1,
    input  logic [7:0] wdata1,
    output logic       done1,
    output logic [7:0] rdata1,
    output logic       err1,

    output logic [1:0] grant,

    output logic       m_start,
    output logic [6:0] m_addr,
    output logic       m_rw,
    output logic [7:0] m_wdata,
    input  logic       m_busy,
    input  logic       m_done,
    input  logic [7:0] m_rdata,
    input  logic       m_nack,

    output logic       abort
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_t;

    state_t r_state;
    logic   r_owner;
    logic   r_last;

    logic   w_any;
    logic   w_pick;

`ifdef I2C_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // On a tie the requester that did not own the bus last wins; r_last resets to 1
    // so requester 0 takes the first tie.
    assign w_any  = req0 | req1;
    assign w_pick = (req0 && req1) ? ~r_last : req1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            grant   <= 2'b00;
            m_start <= 1'b0;
            m_addr  <= 7'h00;
            m_rw    <= 1'b0;
            m_wdata <= 8'h00;
            abort   <= 1'b0;
            done0   <= 1'b0;
            rdata0  <= 8'h00;
            err0    <= 1'b0;
            done1   <= 1'b0;
            rdata1  <= 8'h00;
            err1    <= 1'b0;
`ifdef I2C_ARBITER_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            m_start <= 1'b0;
            abort   <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (w_any && !m_busy) begin
                        r_owner <= w_pick;
                        grant   <= w_pick ? 2'b10 : 2'b01;
                        m_addr  <= w_pick ? addr1 : addr0;
                        m_rw    <= w_pick ? rw1 : rw0;
                        m_wdata <= w_pick ? wdata1 : wdata0;
                        r_state <= StIssue;
                    end
                end

                StIssue: begin
                    m_start <= 1'b1;
                    r_state <= StWait;
                end

                // Completion takes precedence over a coincident timeout.
                StWait: begin
                    if (m_done) begin
                        if (r_owner) begin
                            rdata1 <= m_rw ? m_rdata : 8'h00;
                            err1   <= m_nack;
                            done1  <= 1'b1;
                        end else begin
                            rdata0 <= m_rw ? m_rdata : 8'h00;
                            err0   <= m_nack;
                            done0  <= 1'b1;
                        end
                        r_state <= StResp;
                    end
`ifdef I2C_ARBITER_TIMEOUT_EN
                    else if (r_cnt == CNT_LAST) begin
                        abort <= 1'b1;
                        if (r_owner) begin
                            rdata1 <= 8'h00;
                            err1   <= 1'b1;
                            done1  <= 1'b1;
                        end else begin
                            rdata0 <= 8'h00;
                            err0   <= 1'b1;
                            done0  <= 1'b1;
                        end
                        r_state <= StResp;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end

                StResp: begin
                    grant   <= 2'b00;
                    r_last  <= r_owner;
`ifdef I2C_ARBITER_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scoreboard bench for i2c_arbiter: drivers raise requests, a master model answers,
// and one monitor pops expected starts, completions and aborts as the DUT emits them.
module tb_i2c_arbiter;

    localparam int unsigned TO = 100;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
    } req_t;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        logic [1:0] grant;
    } start_t;

    typedef struct {
        int         who;
        logic [7:0] rdata;
        logic       err;
    } done_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0, rw0, req1, rw1;
    logic [6:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       done0, err0, done1, err1;
    logic [7:0] rdata0, rdata1;
    logic [1:0] grant;
    logic       m_start, m_rw, m_busy, m_done, m_nack, abort;
    logic [6:0] m_addr;
    logic [7:0] m_wdata, m_rdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_start = 0;
    int req0_cyc = 0;

    req_t   rq0[$];
    req_t   rq1[$];
    start_t exp_start[$];
    done_t  exp_done[$];
    int     exp_abort[$];

    logic [7:0] last_rd[2];
    logic       last_err[2];
    logic       prev_start = 1'b0;

    // Master model configuration, written only by the test sequence.
    int         dly = 20;
    logic       silent = 1'b0;
    logic [7:0] cfg_rdata = 8'h00;
    logic       cfg_nack = 1'b0;
    int         kick = 0;
    int         m_cnt = -1;
    int         m_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (req0),
        .addr0   (addr0),
        .rw0     (rw0),
        .wdata0  (wdata0),
        .done0   (done0),
        .rdata0  (rdata0),
        .err0    (err0),
        .req1    (req1),
        .addr1   (addr1),
        .rw1     (rw1),
        .wdata1  (wdata1),
        .done1   (done1),
        .rdata1  (rdata1),
        .err1    (err1),
        .grant   (grant),
        .m_start (m_start),
        .m_addr  (m_addr),
        .m_rw    (m_rw),
        .m_wdata (m_wdata),
        .m_busy  (m_busy),
        .m_done  (m_done),
        .m_rdata (m_rdata),
        .m_nack  (m_nack),
        .abort   (abort)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_req(input int n, input logic [6:0] a, input logic rw, input logic [7:0] wd);
        req_t it;
        it.addr = a; it.rw = rw; it.wdata = wd;
        if (n == 0) rq0.push_back(it);
        else rq1.push_back(it);
    endtask

    task automatic push_start(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                              input logic [1:0] g);
        start_t s;
        s.addr = a; s.rw = rw; s.wdata = wd; s.grant = g;
        exp_start.push_back(s);
    endtask

    task automatic push_done(input int who, input logic [7:0] rd, input logic err);
        done_t d;
        d.who = who; d.rdata = rd; d.err = err;
        exp_done.push_back(d);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_done.size() != 0 || grant != 2'b00) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_done_queue", 32'(exp_done.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Requester drivers: hold the request until done (or reset), scramble own inputs once
    // granted to show the arbiter latched them.
    initial begin : drv0
        req_t it;
        logic got;
        req0 = 1'b0; addr0 = '0; rw0 = 1'b0; wdata0 = '0;
        forever begin
            @(posedge clk); #1;
            if (rq0.size() != 0) begin
                it = rq0.pop_front();
                addr0 = it.addr; rw0 = it.rw; wdata0 = it.wdata; req0 = 1'b1;
                req0_cyc = cyc;
                got = 1'b0;
                for (int n = 0; n < 3000 && !got; n++) begin
                    @(negedge clk);
                    if (grant[0]) begin
                        addr0 = ~it.addr; rw0 = ~it.rw; wdata0 = ~it.wdata;
                    end
                    got = done0 | ~reset_n;
                end
                check("drv0_wait_bound", 32'(got), 32'd1);
                req0 = 1'b0;
            end
        end
    end

    initial begin : drv1
        req_t it;
        logic got;
        req1 = 1'b0; addr1 = '0; rw1 = 1'b0; wdata1 = '0;
        forever begin
            @(posedge clk); #1;
            if (rq1.size() != 0) begin
                it = rq1.pop_front();
                addr1 = it.addr; rw1 = it.rw; wdata1 = it.wdata; req1 = 1'b1;
                got = 1'b0;
                for (int n = 0; n < 3000 && !got; n++) begin
                    @(negedge clk);
                    if (grant[1]) begin
                        addr1 = ~it.addr; rw1 = ~it.rw; wdata1 = ~it.wdata;
                    end
                    got = done1 | ~reset_n;
                end
                check("drv1_wait_bound", 32'(got), 32'd1);
                req1 = 1'b0;
            end
        end
    end

    // I2C master model: answers dly cycles after m_start unless silent; kick forces a pulse.
    initial begin : master
        m_done = 1'b0; m_rdata = 8'hEE; m_nack = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_done = 1'b0; m_rdata = 8'hEE; m_nack = 1'b0;
            if (!reset_n) m_cnt = -1;
            else if (m_start) m_cnt = silent ? -1 : dly;
            else if (m_cnt > 0) m_cnt--;
            if (m_cnt == 0 || kick != m_seen) begin
                m_done = 1'b1; m_rdata = cfg_rdata; m_nack = cfg_nack;
                m_cnt = -1; m_seen = kick;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        start_t s;
        done_t  d;
        int     lat;
        if (!reset_n) begin
            last_rd[0] = 8'h00; last_rd[1] = 8'h00;
            last_err[0] = 1'b0; last_err[1] = 1'b0;
        end
        if (m_start) begin
            last_start = cyc;
            check("start_width", 32'(prev_start), 32'd0);
            if (exp_start.size() == 0) begin
                check("start_unexpected", 32'(m_start), 32'd0);
            end else begin
                s = exp_start.pop_front();
                check("m_addr", 32'(m_addr), 32'(s.addr));
                check("m_rw", 32'(m_rw), 32'(s.rw));
                check("m_wdata", 32'(m_wdata), 32'(s.wdata));
                check("grant_at_start", 32'(grant), 32'(s.grant));
            end
        end
        prev_start = m_start;
        if (done0 || done1) begin
            if (exp_done.size() == 0) begin
                check("done_unexpected", 32'({done1, done0}), 32'd0);
            end else begin
                d = exp_done.pop_front();
                check("done_owner", 32'({done1, done0}), (d.who == 1) ? 32'd2 : 32'd1);
                last_rd[d.who] = d.rdata;
                last_err[d.who] = d.err;
                check("rdata0", 32'(rdata0), 32'(last_rd[0]));
                check("err0", 32'(err0), 32'(last_err[0]));
                check("rdata1", 32'(rdata1), 32'(last_rd[1]));
                check("err1", 32'(err1), 32'(last_err[1]));
            end
        end
        if (abort) begin
            if (exp_abort.size() == 0) begin
                check("abort_unexpected", 32'(abort), 32'd0);
            end else begin
                lat = exp_abort.pop_front();
                check("abort_latency", 32'(cyc - last_start), 32'(lat));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : test
        m_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_m_start", 32'(m_start), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        check("rst_done", 32'({done1, done0}), 32'd0);
        check("rst_rdata", 32'({rdata1, rdata0}), 32'd0);
        check("rst_err", 32'({err1, err0}), 32'd0);
        check("rst_m_addr", 32'(m_addr), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Stray m_done while idle must be ignored.
        kick++;
        repeat (4) @(negedge clk);

        // Single read on requester 0.
        dly = 20; cfg_rdata = 8'hA5; cfg_nack = 1'b0;
        push_start(7'h50, 1'b1, 8'h11, 2'b01);
        push_done(0, 8'hA5, 1'b0);
        push_req(0, 7'h50, 1'b1, 8'h11);
        wait_idle();
        check("issue_latency", 32'(last_start - req0_cyc), 32'd2);

        // Write on requester 1 with NACK; read data must be forced to zero.
        dly = 5; cfg_rdata = 8'h3C; cfg_nack = 1'b1;
        push_start(7'h2A, 1'b0, 8'hC3, 2'b10);
        push_done(1, 8'h00, 1'b1);
        push_req(1, 7'h2A, 1'b0, 8'hC3);
        wait_idle();

        // Busy master holds the arbiter in IDLE.
        m_busy = 1'b1; cfg_nack = 1'b0;
        push_start(7'h11, 1'b0, 8'h5A, 2'b01);
        push_done(0, 8'h00, 1'b0);
        push_req(0, 7'h11, 1'b0, 8'h5A);
        repeat (10) @(negedge clk);
        check("busy_hold_grant", 32'(grant), 32'd0);
        m_busy = 1'b0;
        wait_idle();

        // Simultaneous requests after reset, requester 0 re-requests back to back.
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        dly = 3; cfg_rdata = 8'h77; cfg_nack = 1'b0;
        push_start(7'h10, 1'b1, 8'h00, 2'b01);
        push_start(7'h20, 1'b1, 8'h00, 2'b10);
        push_start(7'h30, 1'b0, 8'hAB, 2'b01);
        push_done(0, 8'h77, 1'b0);
        push_done(1, 8'h77, 1'b0);
        push_done(0, 8'h00, 1'b0);
        push_req(0, 7'h10, 1'b1, 8'h00);
        push_req(0, 7'h30, 1'b0, 8'hAB);
        push_req(1, 7'h20, 1'b1, 8'h00);
        wait_idle();

        // Next simultaneous pair: requester 0 owned last, so requester 1 goes first.
        push_start(7'h21, 1'b1, 8'h00, 2'b10);
        push_start(7'h11, 1'b1, 8'h00, 2'b01);
        push_done(1, 8'h77, 1'b0);
        push_done(0, 8'h77, 1'b0);
        push_req(0, 7'h11, 1'b1, 8'h00);
        push_req(1, 7'h21, 1'b1, 8'h00);
        wait_idle();

        // Master never answers.
        silent = 1'b1; cfg_rdata = 8'h99;
        push_start(7'h40, 1'b1, 8'h00, 2'b01);
`ifdef I2C_ARBITER_TIMEOUT_EN
        push_done(0, 8'h00, 1'b1);
        exp_abort.push_back(TO);
        push_req(0, 7'h40, 1'b1, 8'h00);
        wait_idle();
        check("post_timeout_grant", 32'(grant), 32'd0);
`else
        push_done(0, 8'h99, 1'b0);
        push_req(0, 7'h40, 1'b1, 8'h00);
        repeat (1000) @(negedge clk);
        check("no_timeout_grant", 32'(grant), 32'd1);
        kick++;
        wait_idle();
`endif

        // Reset in the middle of WAIT: no done or abort, then normal service.
        push_start(7'h33, 1'b1, 8'h00, 2'b10);
        push_req(1, 7'h33, 1'b1, 8'h00);
        repeat (15) @(negedge clk);
        check("pre_reset_grant", 32'(grant), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_pulses", 32'({m_start, abort, done1, done0}), 32'd0);
        check("mid_rst_rdata", 32'({rdata1, rdata0}), 32'd0);
        check("mid_rst_err", 32'({err1, err0}), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        silent = 1'b0;
        repeat (20) @(negedge clk);
        dly = 4; cfg_rdata = 8'h5C;
        push_start(7'h34, 1'b1, 8'h00, 2'b10);
        push_done(1, 8'h5C, 1'b0);
        push_req(1, 7'h34, 1'b1, 8'h00);
        wait_idle();

        repeat (5) @(negedge clk);
        check("start_queue_empty", 32'(exp_start.size()), 32'd0);
        check("abort_queue_empty", 32'(exp_abort.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
